// File: rtl/lzc_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter and its zero-count helper.
package lzc_rr_arbiter_pkg;

   // Bits needed to index `num` items; a single item still gets one bit.
   function automatic int unsigned idx_width(input int unsigned num);
      if (num > 32'd1) begin
         idx_width = $clog2(num);
      end else begin
         idx_width = 32'd1;
      end
   endfunction

endpackage : lzc_rr_arbiter_pkg

// File: rtl/lzc_rr_arbiter_lzc.sv
// Leading/trailing zero counter.
// MODE=0 counts trailing zeros (first set bit from the LSB).
// MODE=1 counts leading zeros (first set bit from the MSB).
// If in_i is all zero, cnt_o is 0 and empty_o is high.
module lzc
   import lzc_rr_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter bit          MODE     = 1'b0,
   parameter int unsigned CntWidth = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0]    in_i,
   output logic [CntWidth-1:0] cnt_o,
   output logic                empty_o
);

   localparam int W = int'(WIDTH);

   logic hit;

   // Priority scan: keep the position of the first set bit in the scan direction.
   always_comb begin
      // NOTE: every output of this block is given a default before the loop.
      // An output left unassigned on some path would infer a latch.
      cnt_o = '0;
      hit   = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (!hit && in_i[(MODE == 1'b1) ? (W - 1 - i) : i]) begin
            cnt_o = CntWidth'(i);
            hit   = 1'b1;
         end
      end
   end

   assign empty_o = ~|in_i;

endmodule : lzc

// File: rtl/lzc_rr_arbiter.sv
// Round-robin arbiter: NumIn valid/ready streams onto one output stream.
// The grant is combinational. A registered pointer gives fairness, and a
// registered lock holds the winner while the output is stalled.
module lzc_rr_arbiter
   import lzc_rr_arbiter_pkg::*;
#(
   parameter int unsigned NumIn     = 4,
   parameter int unsigned DataWidth = 32,
   parameter bit          LockIn    = 1'b1,
   parameter int unsigned IdxWidth  = idx_width(NumIn)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic [NumIn-1:0]           req_i,
   output logic [NumIn-1:0]           gnt_o,
   input  logic [NumIn*DataWidth-1:0] data_i,
   output logic                       req_o,
   input  logic                       gnt_i,
   output logic [DataWidth-1:0]       data_o,
   output logic [IdxWidth-1:0]        idx_o
);

   if (NumIn == 1) begin : gen_pass
      // A single requester needs no arbitration and no state.
      logic unused_ok;
      assign unused_ok = ^{clk_i, rst_i, flush_i};

      assign req_o  = req_i[0];
      assign gnt_o  = req_i & {gnt_i};
      assign data_o = data_i;
      assign idx_o  = '0;

   end else begin : gen_rr

      logic [IdxWidth-1:0] rr_q, rr_d;
      logic                lock_q, lock_d;
      logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;

      logic [NumIn-1:0]    mask;
      logic [NumIn-1:0]    req_masked;
      logic [IdxWidth-1:0] masked_idx, unmasked_idx, idx;
      logic                masked_empty, unmasked_empty;

      // Pointer to the requester after `cur`, wrapping NumIn-1 back to 0.
      // NumIn need not be a power of two.
      function automatic logic [IdxWidth-1:0] next_ptr(input logic [IdxWidth-1:0] cur);
         if (cur == IdxWidth'(NumIn - 1)) begin
            next_ptr = '0;
         end else begin
            next_ptr = cur + 1'b1;
         end
      endfunction

      // Only requesters at or above the pointer take part in the masked search.
      always_comb begin
         mask = '0;
         for (int i = 0; i < int'(NumIn); i++) begin
            mask[i] = (IdxWidth'(i) >= rr_q);
         end
         req_masked = req_i & mask;
      end

      lzc #(
         .WIDTH    (NumIn),
         .MODE     (1'b0),
         .CntWidth (IdxWidth)
      ) u_lzc_masked (
         .in_i    (req_masked),
         .cnt_o   (masked_idx),
         .empty_o (masked_empty)
      );

      lzc #(
         .WIDTH    (NumIn),
         .MODE     (1'b0),
         .CntWidth (IdxWidth)
      ) u_lzc_unmasked (
         .in_i    (req_i),
         .cnt_o   (unmasked_idx),
         .empty_o (unmasked_empty)
      );

      // Pick the winner: a held lock first, then the masked search,
      // then the unmasked fallback. Drive the output side from it.
      always_comb begin
         idx = masked_empty ? unmasked_idx : masked_idx;
         if (LockIn && lock_q) begin
            idx = lock_idx_q;
         end

         req_o = (LockIn && lock_q) ? req_i[lock_idx_q] : ~unmasked_empty;

         data_o = data_i[idx*DataWidth +: DataWidth];
         idx_o  = idx;

         gnt_o = '0;
         if (req_o && gnt_i) begin
            gnt_o[idx] = 1'b1;
         end
      end

      // Next state. A handshake advances the pointer and releases the lock.
      // A stall locks the winner. If the request drops, the lock is released.
      // flush_i overrides everything else.
      always_comb begin
         rr_d       = rr_q;
         lock_d     = lock_q;
         lock_idx_d = lock_idx_q;

         if (req_o && gnt_i) begin
            rr_d   = next_ptr(idx);
            lock_d = 1'b0;
         end else if (req_o && LockIn) begin
            lock_d     = 1'b1;
            lock_idx_d = idx;
         end else if (!req_o) begin
            lock_d = 1'b0;
         end

         if (flush_i) begin
            rr_d   = '0;
            lock_d = 1'b0;
         end
      end

      // State registers, cleared asynchronously.
      always_ff @(posedge clk_i or posedge rst_i) begin
         // NOTE: state registers use non-blocking assignments.
         // With blocking assignments, same-edge readers of these registers
         // would depend on process ordering.
         if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
         end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
         end
      end

      // A locked requester must keep its request and payload steady until granted.
      a_lock_stable: assert property (@(posedge clk_i) disable iff (rst_i)
         lock_q |-> (req_i[lock_idx_q] && (data_o == $past(data_o))));

   end

   a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(gnt_o));

   a_idx_range: assert property (@(posedge clk_i) disable iff (rst_i)
      idx_o <= IdxWidth'(NumIn - 1));

   a_gnt_needs_req: assert property (@(posedge clk_i) disable iff (rst_i)
      (|gnt_o) |-> req_o);

endmodule : lzc_rr_arbiter

// File: tb/tb_lzc_rr_arbiter.sv
// Self-checking bench for lzc_rr_arbiter.
// A cycle table drives a locking and a non-locking 4-input instance in
// parallel. Hand sequences cover reset mid-stall, a 3-input wrap and
// the single-input pass-through.
module tb_lzc_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [3:0]  req;
   logic        gnt;
   logic [127:0] data;

   logic [3:0]  gnt_o_l, gnt_o_n;
   logic        req_o_l, req_o_n;
   logic [31:0] data_o_l, data_o_n;
   logic [1:0]  idx_o_l, idx_o_n;

   logic [2:0]  req3;
   logic        gnt3;
   logic [95:0] data3;
   logic [2:0]  gnt_o3;
   logic        req_o3;
   logic [31:0] data_o3;
   logic [1:0]  idx_o3;

   logic [0:0]  req1;
   logic        gnt1;
   logic [31:0] data1;
   logic [0:0]  gnt_o1;
   logic        req_o1;
   logic [31:0] data_o1;
   logic [0:0]  idx_o1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lzc_rr_arbiter #(.NumIn(4), .DataWidth(32), .LockIn(1'b1)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_i(req), .gnt_o(gnt_o_l),
      .data_i(data), .req_o(req_o_l), .gnt_i(gnt), .data_o(data_o_l), .idx_o(idx_o_l));

   lzc_rr_arbiter #(.NumIn(4), .DataWidth(32), .LockIn(1'b0)) u_dut_nl (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_i(req), .gnt_o(gnt_o_n),
      .data_i(data), .req_o(req_o_n), .gnt_i(gnt), .data_o(data_o_n), .idx_o(idx_o_n));

   lzc_rr_arbiter #(.NumIn(3), .DataWidth(32), .LockIn(1'b1)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_i(req3), .gnt_o(gnt_o3),
      .data_i(data3), .req_o(req_o3), .gnt_i(gnt3), .data_o(data_o3), .idx_o(idx_o3));

   lzc_rr_arbiter #(.NumIn(1), .DataWidth(32), .LockIn(1'b1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_i(req1), .gnt_o(gnt_o1),
      .data_i(data1), .req_o(req_o1), .gnt_i(gnt1), .data_o(data_o1), .idx_o(idx_o1));

   typedef struct {
      logic       flush;
      logic [3:0] req;
      logic       gnt;
      logic [1:0] idx;
      logic       req_o;
      logic [1:0] idx_nl;
   } vec_t;

   typedef struct {
      logic        req_o;
      logic [3:0]  gnt;
      logic [1:0]  idx;
      logic [31:0] data;
      logic        req_nl;
      logic [3:0]  gnt_nl;
      logic [1:0]  idx_nl;
      logic [31:0] data_nl;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[22];

   function automatic logic [31:0] data_of(input int i);
      return 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus and queue what both 4-input instances must show.
   task automatic drive(input logic fl, input logic [3:0] rq, input logic g,
                        input logic [1:0] ei, input logic er, input logic [1:0] ein);
      exp_t e;
      @(posedge clk);
      #1;
      flush = fl;
      req   = rq;
      gnt   = g;
      e.req_o   = er;
      e.idx     = ei;
      e.gnt     = (er && g) ? (4'b0001 << ei) : 4'b0000;
      e.data    = data_of(int'(ei));
      e.req_nl  = |rq;
      e.idx_nl  = ein;
      e.gnt_nl  = ((|rq) && g) ? (4'b0001 << ein) : 4'b0000;
      e.data_nl = data_of(int'(ein));
      sb.push_back(e);
   endtask

   // Scoreboard: compare queued expectations on the falling edge, away from state updates.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         check("lock_req_o", 64'(req_o_l),  64'(e.req_o));
         check("lock_gnt_o", 64'(gnt_o_l),  64'(e.gnt));
         check("lock_idx_o", 64'(idx_o_l),  64'(e.idx));
         check("lock_data",  64'(data_o_l), 64'(e.data));
         check("nl_req_o",   64'(req_o_n),  64'(e.req_nl));
         check("nl_gnt_o",   64'(gnt_o_n),  64'(e.gnt_nl));
         check("nl_idx_o",   64'(idx_o_n),  64'(e.idx_nl));
         check("nl_data",    64'(data_o_n), 64'(e.data_nl));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] exp3;

      // Reset, then 1111 with gnt held (idx 0,1,2,3,0).
      vecs[0]  = '{1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 2'd0};
      vecs[1]  = '{1'b0, 4'b1111, 1'b1, 2'd1, 1'b1, 2'd1};
      vecs[2]  = '{1'b0, 4'b1111, 1'b1, 2'd2, 1'b1, 2'd2};
      vecs[3]  = '{1'b0, 4'b1111, 1'b1, 2'd3, 1'b1, 2'd3};
      vecs[4]  = '{1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 2'd0};
      // No requests: outputs idle, registers hold.
      vecs[5]  = '{1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd0};
      // rr=1 -> 1, then rr=2 with 0011 falls back to 0, then rr=1 -> 1.
      vecs[6]  = '{1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 2'd1};
      vecs[7]  = '{1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, 2'd0};
      vecs[8]  = '{1'b0, 4'b0011, 1'b1, 2'd1, 1'b1, 2'd1};
      // Bring rr back to 0.
      vecs[9]  = '{1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 2'd3};
      // Stall on 0110, then 0111: locked instance stays on 1, other moves to 0.
      vecs[10] = '{1'b0, 4'b0110, 1'b0, 2'd1, 1'b1, 2'd1};
      vecs[11] = '{1'b0, 4'b0110, 1'b0, 2'd1, 1'b1, 2'd1};
      vecs[12] = '{1'b0, 4'b0110, 1'b0, 2'd1, 1'b1, 2'd1};
      vecs[13] = '{1'b0, 4'b0111, 1'b0, 2'd1, 1'b1, 2'd0};
      vecs[14] = '{1'b0, 4'b0111, 1'b1, 2'd1, 1'b1, 2'd0};
      // Pointers now differ: locking rr=2, non-locking rr=1.
      vecs[15] = '{1'b0, 4'b1111, 1'b1, 2'd2, 1'b1, 2'd1};
      // Flush together with a handshake on idx 2: rr goes to 0, not 3.
      vecs[16] = '{1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 2'd2};
      vecs[17] = '{1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 2'd0};
      // Lock on 3, then flush while locked: flush-cycle outputs unchanged, lock gone next.
      vecs[18] = '{1'b0, 4'b1000, 1'b0, 2'd3, 1'b1, 2'd3};
      vecs[19] = '{1'b1, 4'b1001, 1'b0, 2'd3, 1'b1, 2'd3};
      vecs[20] = '{1'b0, 4'b1001, 1'b0, 2'd0, 1'b1, 2'd0};
      vecs[21] = '{1'b0, 4'b1001, 1'b1, 2'd0, 1'b1, 2'd0};

      for (int i = 0; i < 4; i++) data[i*32 +: 32] = data_of(i);
      for (int i = 0; i < 3; i++) data3[i*32 +: 32] = data_of(i);
      data1 = data_of(7);

      rst = 1'b1; flush = 1'b0; req = 4'b0000; gnt = 1'b0;
      req3 = 3'b000; gnt3 = 1'b0; req1 = 1'b0; gnt1 = 1'b0;

      #2;
      check("rst_req_o", 64'(req_o_l), 64'd0);
      check("rst_gnt_o", 64'(gnt_o_l), 64'd0);
      check("rst_idx_o", 64'(idx_o_l), 64'd0);
      check("rst_data",  64'(data_o_l), 64'(data_of(0)));
      req = 4'b1110; gnt = 1'b1;
      #1;
      check("rst_comb_idx", 64'(idx_o_l), 64'd1);
      check("rst_comb_gnt", 64'(gnt_o_l), 64'h2);
      req = 4'b0000; gnt = 1'b0;
      #9;
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         drive(vecs[i].flush, vecs[i].req, vecs[i].gnt,
               vecs[i].idx, vecs[i].req_o, vecs[i].idx_nl);
      end

      // Reset in the middle of a stall locked on idx 3 (both pointers are 1 here).
      drive(1'b0, 4'b1000, 1'b0, 2'd3, 1'b1, 2'd3);
      drive(1'b0, 4'b1000, 1'b0, 2'd3, 1'b1, 2'd3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      req = 4'b1001;
      #1;
      check("midrst_idx", 64'(idx_o_l), 64'd0);
      check("midrst_req", 64'(req_o_l), 64'd1);
      check("midrst_data", 64'(data_o_l), 64'(data_of(0)));
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("postrst_idx", 64'(idx_o_l), 64'd0);
      drive(1'b0, 4'b1001, 1'b1, 2'd0, 1'b1, 2'd0);
      drive(1'b0, 4'b1001, 1'b1, 2'd3, 1'b1, 2'd3);
      @(posedge clk);
      #1;
      req = 4'b0000; gnt = 1'b0;

      // Three requesters: the pointer wraps 2 -> 0.
      for (int k = 0; k < 4; k++) begin
         exp3 = 2'(k % 3);
         @(posedge clk);
         #1;
         req3 = 3'b111; gnt3 = 1'b1;
         #1;
         check("n3_idx",  64'(idx_o3),  64'(exp3));
         check("n3_gnt",  64'(gnt_o3),  64'(3'b001 << exp3));
         check("n3_data", 64'(data_o3), 64'(data_of(int'(exp3))));
      end
      req3 = 3'b000; gnt3 = 1'b0;

      // Single requester: pass-through.
      @(posedge clk);
      #1;
      req1 = 1'b1; gnt1 = 1'b1;
      #1;
      check("n1_req_o", 64'(req_o1), 64'd1);
      check("n1_gnt",   64'(gnt_o1), 64'd1);
      check("n1_idx",   64'(idx_o1), 64'd0);
      check("n1_data",  64'(data_o1), 64'(data_of(7)));
      gnt1 = 1'b0;
      #1;
      check("n1_stall_gnt", 64'(gnt_o1), 64'd0);
      req1 = 1'b0; gnt1 = 1'b1;
      #1;
      check("n1_idle_req", 64'(req_o1), 64'd0);
      check("n1_idle_gnt", 64'(gnt_o1), 64'd0);
      gnt1 = 1'b0;

      @(negedge clk);
      #1;
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_lzc_rr_arbiter
